pp_pipeline_accel_div_seq_22s_11ns_22: RTL

- Sequential radix-2 restoring divider. It is the inverse operator of the pipeline's 11-bit-unsigned × 22-bit-signed multiplier.
- Computes a 22-bit signed quotient and a 12-bit signed remainder from a 22-bit signed dividend and an 11-bit unsigned divisor.
- Used by the pp_pipeline_accel normalisation and rescale paths, where a value scaled by the multiplier must be brought back to its original range.
- Iterative, one quotient bit per cycle. Valid/ready handshake on both sides, plus the pipeline-wide ce stall.

---
 rtl/pp_pipeline_accel_div_seq_22s_11ns_22.sv | 126 ++++++++++++
 1 files changed

// File: rtl/pp_pipeline_accel_div_seq_22s_11ns_22.sv
// Sequential radix-2 restoring divider: signed dividend / unsigned divisor.
// Produces one quotient bit per enabled cycle. Valid/ready on both sides, plus a ce stall.
module pp_pipeline_accel_div_seq_22s_11ns_22 #(
    parameter int unsigned DIVIDEND_WIDTH = 22,
    parameter int unsigned DIVISOR_WIDTH  = 11,
    parameter int unsigned REM_WIDTH      = 12
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ce,
    input  logic                      in_vld,
    output logic                      in_rdy,
    input  logic [DIVIDEND_WIDTH-1:0] dividend,
    input  logic [DIVISOR_WIDTH-1:0]  divisor,
    output logic                      out_vld,
    input  logic                      out_rdy,
    output logic [DIVIDEND_WIDTH-1:0] quotient,
    output logic [REM_WIDTH-1:0]      remainder,
    output logic                      div_by_zero
);

    localparam int unsigned CntW = $clog2(DIVIDEND_WIDTH);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e                    state_q, state_d;
    logic [CntW-1:0]           cnt_q;
    logic [DIVIDEND_WIDTH-1:0] mag_q;      // dividend magnitude, refilled with quotient bits
    logic [DIVISOR_WIDTH-1:0]  dvsr_q;
    logic [DIVISOR_WIDTH-1:0]  part_rem_q;
    logic                      sign_q;

    logic [REM_WIDTH-1:0]      shifted;
    logic [REM_WIDTH:0]        trial;
    logic                      qbit;
    logic [REM_WIDTH-1:0]      rem_next;
    logic [DIVIDEND_WIDTH-1:0] mag_next;
    logic [DIVIDEND_WIDTH-1:0] quot_final;
    logic [REM_WIDTH-1:0]      rem_final;
    logic                      dbz;
    logic [DIVIDEND_WIDTH-1:0] dividend_abs;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else if (ce) begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (in_vld) state_d = StCalc;
            StCalc:  if (cnt_q == '0) state_d = StDone;
            StDone:  if (out_rdy) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        in_rdy  = (state_q == StIdle);
        out_vld = (state_q == StDone);
    end

    // One restoring step: shift in next magnitude bit, trial-subtract the divisor
    always_comb begin
        shifted  = {part_rem_q, mag_q[DIVIDEND_WIDTH-1]};
        trial    = {1'b0, shifted} - {2'b00, dvsr_q};
        qbit     = ~trial[REM_WIDTH];
        rem_next = qbit ? trial[REM_WIDTH-1:0] : shifted;
        mag_next = {mag_q[DIVIDEND_WIDTH-2:0], qbit};
        dbz      = (dvsr_q == '0);
        dividend_abs = dividend[DIVIDEND_WIDTH-1] ? (~dividend + 1'b1) : dividend;

        if (dbz) begin
            quot_final = sign_q ? {1'b1, {(DIVIDEND_WIDTH-1){1'b0}}}
                                : {1'b0, {(DIVIDEND_WIDTH-1){1'b1}}};
            rem_final  = '0;
        end else begin
            quot_final = sign_q ? (~mag_next + 1'b1) : mag_next;
            rem_final  = sign_q ? (~rem_next + 1'b1) : rem_next;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= '0;
            mag_q       <= '0;
            dvsr_q      <= '0;
            part_rem_q  <= '0;
            sign_q      <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (ce) begin
            case (state_q)
                StIdle: begin
                    if (in_vld) begin
                        mag_q      <= dividend_abs;
                        dvsr_q     <= divisor;
                        sign_q     <= dividend[DIVIDEND_WIDTH-1];
                        part_rem_q <= '0;
                        cnt_q      <= CntW'(DIVIDEND_WIDTH - 1);
                    end
                end
                StCalc: begin
                    mag_q      <= mag_next;
                    part_rem_q <= rem_next[DIVISOR_WIDTH-1:0];
                    cnt_q      <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        quotient    <= quot_final;
                        remainder   <= rem_final;
                        div_by_zero <= dbz;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
